// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
// Opcodes 11..(2**M-1) are undefined and complete with flag_err set.
package alu_pkg;

    localparam int OP_RCA      = 0;
    localparam int OP_RCS      = 1;
    localparam int OP_AND      = 2;
    localparam int OP_OR       = 3;
    localparam int OP_XOR      = 4;
    localparam int OP_SHIFT_LS = 5;
    localparam int OP_SHIFT_LD = 6;
    localparam int OP_SHIFT_AS = 7;
    localparam int OP_SHIFT_AD = 8;
    localparam int OP_MUL      = 9;
    localparam int OP_DIV      = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative N-cycle unsigned shift-add multiplier and restoring divider.
// The divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_isDiv,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_lo,
    output logic [N-1:0] o_hi
);

    localparam int CW = $clog2(N + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_b;
    logic [N:0]    w_mulSum;
    logic [N-1:0]  w_nextHi;
    logic [N-1:0]  w_nextLo;

`ifdef ALU_SEQ_DIV_EN
    logic          r_isDiv;
    logic [N:0]    w_divShift;
    logic [N:0]    w_divDiff;
`else
    logic          w_unusedIsDiv;
    assign w_unusedIsDiv = i_isDiv;
`endif

    // MUL keeps {hi,lo} as a right-shifting product; DIV keeps {remainder,quotient} shifting left.
    always_comb begin
        w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_nextHi = w_mulSum[N:1];
        w_nextLo = {w_mulSum[0], r_lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
        w_divShift = {r_hi, r_lo[N-1]};
        w_divDiff  = w_divShift - {1'b0, r_b};
        if (r_isDiv) begin
            w_nextHi = w_divDiff[N] ? w_divShift[N-1:0] : w_divDiff[N-1:0];
            w_nextLo = {r_lo[N-2:0], ~w_divDiff[N]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            o_done  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_isDiv <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_lo    <= i_a;
                r_b     <= i_b;
`ifdef ALU_SEQ_DIV_EN
                r_isDiv <= i_isDiv;
`endif
            end else if (r_busy) begin
                r_hi  <= w_nextHi;
                r_lo  <= w_nextLo;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

    assign o_lo = r_lo;
    assign o_hi = r_hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; MUL (and DIV when ALU_SEQ_DIV_EN
// is defined) run on the iterative alu_seq_muldiv engine, all else takes 2 cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [M-1:0] sel,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic [N-1:0] res_hi,
    output logic         cout,
    output logic         flag_neg,
    output logic         flag_overflow,
    output logic         flag_null,
    output logic         flag_err
);

    localparam int SW = $clog2(N);

    state_t         r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [M-1:0]   r_sel;
    logic           r_cin;
    logic [N-1:0]   r_res;
    logic [N-1:0]   r_resHi;
    logic           r_cout;
    logic           r_neg;
    logic           r_ovf;
    logic           r_null;
    logic           r_err;

    logic           w_isMul;
    logic           w_isDiv;
    logic           w_iterOp;
    logic           w_start;
    logic           w_mdDone;
    logic [N-1:0]   w_mdLo;
    logic [N-1:0]   w_mdHi;
    logic [SW-1:0]  w_shamt;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_wide;
    logic [N-1:0]   w_res;
    logic [N-1:0]   w_resHi;
    logic           w_cout;
    logic           w_ovf;
    logic           w_err;

    assign w_isMul = (sel == M'(OP_MUL));
    assign w_isDiv = (sel == M'(OP_DIV));
`ifdef ALU_SEQ_DIV_EN
    // Divide-by-zero bypasses the engine and finishes on the short path.
    assign w_iterOp = w_isMul || (w_isDiv && (b != '0));
`else
    assign w_iterOp = w_isMul;
`endif
    assign w_start = in_valid && (r_state == IDLE) && w_iterOp;

    alu_seq_muldiv #(.N(N)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_isDiv (w_isDiv),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mdDone),
        .o_lo    (w_mdLo),
        .o_hi    (w_mdHi)
    );

    assign w_shamt = r_b[SW-1:0];

    always_comb begin
        w_res   = '0;
        w_resHi = '0;
        w_cout  = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_sum   = '0;
        w_wide  = {{N{1'b0}}, r_a} << w_shamt;
        case (r_sel)
            M'(OP_RCA): begin
                w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{N{1'b0}}, r_cin};
                w_res  = w_sum[N-1:0];
                w_cout = w_sum[N];
                w_ovf  = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
            end
            M'(OP_RCS): begin
                w_sum  = {1'b0, r_a} - {1'b0, r_b} - {{N{1'b0}}, r_cin};
                w_res  = w_sum[N-1:0];
                w_cout = ~w_sum[N];
                w_ovf  = (r_a[N-1] != r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
            end
            M'(OP_AND):      w_res = r_a & r_b;
            M'(OP_OR):       w_res = r_a | r_b;
            M'(OP_XOR):      w_res = r_a ^ r_b;
            M'(OP_SHIFT_LS): w_res = w_wide[N-1:0];
            M'(OP_SHIFT_LD): w_res = r_a >> w_shamt;
            M'(OP_SHIFT_AS): begin
                w_res = w_wide[N-1:0];
                w_ovf = (w_wide[2*N-1:N] != '0) || (w_wide[N-1] != r_a[N-1]);
            end
            M'(OP_SHIFT_AD): w_res = $unsigned($signed(r_a) >>> w_shamt);
`ifdef ALU_SEQ_DIV_EN
            M'(OP_DIV): begin
                w_res   = '1;
                w_resHi = r_a;
                w_err   = 1'b1;
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_cin   <= 1'b0;
            r_res   <= '0;
            r_resHi <= '0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_null  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= sel;
                        r_cin   <= cin;
                        r_state <= w_iterOp ? ITER : EXEC;
                    end
                end
                EXEC: begin
                    r_res   <= w_res;
                    r_resHi <= w_resHi;
                    r_cout  <= w_cout;
                    r_neg   <= w_res[N-1];
                    r_ovf   <= w_ovf;
                    r_null  <= (w_res == '0);
                    r_err   <= w_err;
                    r_state <= DONE;
                end
                ITER: begin
                    if (w_mdDone) begin
                        r_res   <= w_mdLo;
                        r_resHi <= w_mdHi;
                        r_cout  <= 1'b0;
                        r_neg   <= w_mdLo[N-1];
                        r_err   <= 1'b0;
                        r_state <= DONE;
                        if (r_sel == M'(OP_MUL)) begin
                            r_ovf  <= (w_mdHi != '0);
                            r_null <= ({w_mdHi, w_mdLo} == '0);
                        end else begin
                            r_ovf  <= 1'b0;
                            r_null <= (w_mdLo == '0);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign res           = r_res;
    assign res_hi        = r_resHi;
    assign cout          = r_cout;
    assign flag_neg      = r_neg;
    assign flag_overflow = r_ovf;
    assign flag_null     = r_null;
    assign flag_err      = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expectations, a monitor pops on transfer.
// DIV expectations follow ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int N    = 32;
    localparam int M    = 4;
    localparam int LAT1 = 2;
    localparam int LATN = N + 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] sel;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res;
    logic [N-1:0] res_hi;
    logic         cout;
    logic         flag_neg;
    logic         flag_overflow;
    logic         flag_null;
    logic         flag_err;

    typedef struct {
        string        name;
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic [4:0]   flags;
        int           lat;
        int           reqCycle;
    } exp_t;

    exp_t expQ[$];
    int   errorCount = 0;
    int   checkCount = 0;
    int   cycleCount = 0;

    logic [4:0] dutFlags;
    assign dutFlags = {cout, flag_neg, flag_overflow, flag_null, flag_err};

    alu_seq #(.N(N), .M(M)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .sel           (sel),
        .cin           (cin),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res           (res),
        .res_hi        (res_hi),
        .cout          (cout),
        .flag_neg      (flag_neg),
        .flag_overflow (flag_overflow),
        .flag_null     (flag_null),
        .flag_err      (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        checkCount++;
        if (act !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Issue one request once in_ready is seen; the expected response goes on the scoreboard.
    task automatic applyStimulus(input string name, input int op, input logic [N-1:0] opA,
                                 input logic [N-1:0] opB, input logic opCin, input logic [N-1:0] eRes,
                                 input logic [N-1:0] eHi, input logic [4:0] eFlags, input int eLat,
                                 input bit track);
        int waited = 0;
        while (!in_ready && waited < 300) begin
            nextCycle();
            waited++;
        end
        if (!in_ready) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s.inReadyTimeout: got in_ready=0, expected 1", name);
            return;
        end
        sel      = M'(op);
        a        = opA;
        b        = opB;
        cin      = opCin;
        in_valid = 1'b1;
        if (track) expQ.push_back('{name, eRes, eHi, eFlags, eLat, cycleCount});
        nextCycle();
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((expQ.size() != 0 || out_valid || !in_ready) && n < 200) begin
            nextCycle();
            n++;
        end
        if (n >= 200) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drainTimeout: got %0d pending, expected 0", expQ.size());
        end
    endtask

    // Monitor: latency on first out_valid, full compare on transfer, stability while stalled.
    initial begin
        exp_t        e;
        logic        validSeen;
        logic        holding;
        logic [68:0] snap;
        validSeen = 1'b0;
        holding   = 1'b0;
        snap      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                validSeen = 1'b0;
                holding   = 1'b0;
            end else begin
                if (holding) checkOutput("holdStable", 128'({res_hi, res, dutFlags}), 128'(snap));
                holding = 1'b0;
                if (out_valid) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL unexpectedValid: got out_valid=1 res=0x%0h, expected no result", res);
                    end else begin
                        if (!validSeen) begin
                            checkOutput({expQ[0].name, ".latency"}, 128'(cycleCount - expQ[0].reqCycle),
                                        128'(expQ[0].lat));
                            validSeen = 1'b1;
                        end
                        if (out_ready) begin
                            e = expQ.pop_front();
                            checkOutput({e.name, ".res"}, 128'(res), 128'(e.res));
                            checkOutput({e.name, ".resHi"}, 128'(res_hi), 128'(e.hi));
                            checkOutput({e.name, ".flags"}, 128'(dutFlags), 128'(e.flags));
                            validSeen = 1'b0;
                        end else begin
                            holding = 1'b1;
                            snap    = {res_hi, res, dutFlags};
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Flags are packed {cout, neg, overflow, null, err}.
    initial begin
        int highs;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sel       = '0;
        cin       = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (3) nextCycle();
        checkOutput("resetOutValid", 128'(out_valid), 128'(0));
        checkOutput("resetRes", 128'({res_hi, res}), 128'(0));
        checkOutput("resetFlags", 128'(dutFlags), 128'(0));
        rst_n = 1'b1;
        nextCycle();
        checkOutput("resetInReady", 128'(in_ready), 128'(1));

        applyStimulus("rcaBasic",    OP_RCA, 32'd1,          32'd1,          1'b0, 32'd2,          '0, 5'b00000, LAT1, 1'b1);
        applyStimulus("rcaOvf",      OP_RCA, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  '0, 5'b01100, LAT1, 1'b1);
        applyStimulus("rcsZero",     OP_RCS, 32'd2,          32'd2,          1'b0, 32'd0,          '0, 5'b10010, LAT1, 1'b1);
        applyStimulus("rcaCarry",    OP_RCA, 32'hFFFF_FFFF,  32'd0,          1'b1, 32'd0,          '0, 5'b10010, LAT1, 1'b1);
        applyStimulus("rcsBorrow",   OP_RCS, 32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  '0, 5'b01000, LAT1, 1'b1);
        applyStimulus("rcsOvf",      OP_RCS, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  '0, 5'b10100, LAT1, 1'b1);
        applyStimulus("andOp",       OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  1'b1, 32'hF000_F000,  '0, 5'b01000, LAT1, 1'b1);
        applyStimulus("orOp",        OP_OR,  32'h0000_0F00,  32'h0000_00F0,  1'b0, 32'h0000_0FF0,  '0, 5'b00000, LAT1, 1'b1);
        applyStimulus("xorOp",       OP_XOR, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  1'b0, 32'd0,          '0, 5'b00010, LAT1, 1'b1);
        applyStimulus("shlsMax",     OP_SHIFT_LS, 32'd1,     32'd31,         1'b0, 32'h8000_0000,  '0, 5'b01000, LAT1, 1'b1);
        applyStimulus("shlsAmtBits", OP_SHIFT_LS, 32'd1,     32'h21,         1'b0, 32'd2,          '0, 5'b00000, LAT1, 1'b1);
        applyStimulus("shld",        OP_SHIFT_LD, 32'h8000_0002, 32'd1,      1'b0, 32'h4000_0001,  '0, 5'b00000, LAT1, 1'b1);
        applyStimulus("shad",        OP_SHIFT_AD, 32'h8000_0002, 32'd1,      1'b0, 32'hC000_0001,  '0, 5'b01000, LAT1, 1'b1);
        applyStimulus("shasSign",    OP_SHIFT_AS, 32'h4000_0000, 32'd1,      1'b0, 32'h8000_0000,  '0, 5'b01100, LAT1, 1'b1);
        applyStimulus("shasOk",      OP_SHIFT_AS, 32'd3,     32'd2,          1'b0, 32'h0000_000C,  '0, 5'b00000, LAT1, 1'b1);
        applyStimulus("shasLost",    OP_SHIFT_AS, 32'hC000_0000, 32'd1,      1'b0, 32'h8000_0000,  '0, 5'b01100, LAT1, 1'b1);
        applyStimulus("undefOp",     15,     32'd123,        32'd5,          1'b0, 32'd0,          '0, 5'b00011, LAT1, 1'b1);
        waitIdle();

        applyStimulus("mulBig", OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFE, 32'd1, 5'b01100, LATN, 1'b1);
        highs = 0;
        for (int i = 0; i <= N; i++) begin
            if (in_ready) highs++;
            if (i < N) nextCycle();
        end
        checkOutput("mulInReadyLow", 128'(highs), 128'(0));
        applyStimulus("mulSmall", OP_MUL, 32'h1234, 32'h100, 1'b0, 32'h0012_3400, 32'd0, 5'b00000, LATN, 1'b1);
        applyStimulus("mulZero",  OP_MUL, 32'd0,    32'd5,   1'b0, 32'd0,         32'd0, 5'b00010, LATN, 1'b1);
`ifdef ALU_SEQ_DIV_EN
        applyStimulus("div",      OP_DIV, 32'd100, 32'd7, 1'b0, 32'd14,         32'd2,   5'b00000, LATN, 1'b1);
        applyStimulus("divZero",  OP_DIV, 32'd5,   32'd0, 1'b0, 32'hFFFF_FFFF,  32'd5,   5'b01001, LAT1, 1'b1);
`else
        applyStimulus("div",      OP_DIV, 32'd100, 32'd7, 1'b0, 32'd0,          32'd0,   5'b00011, LAT1, 1'b1);
        applyStimulus("divZero",  OP_DIV, 32'd5,   32'd0, 1'b0, 32'd0,          32'd0,   5'b00011, LAT1, 1'b1);
`endif
        waitIdle();

        out_ready = 1'b0;
        applyStimulus("holdRca", OP_RCA, 32'd3, 32'd4, 1'b0, 32'd7, '0, 5'b00000, LAT1, 1'b1);
        repeat (6) nextCycle();
        out_ready = 1'b1;
        waitIdle();

        applyStimulus("mulAborted", OP_MUL, 32'd9, 32'd9, 1'b0, '0, '0, 5'b00000, LATN, 1'b0);
        repeat (10) nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("abortOutValid", 128'(out_valid), 128'(0));
        checkOutput("abortRes", 128'({res_hi, res, dutFlags}), 128'(0));
        repeat (2) nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("abortInReady", 128'(in_ready), 128'(1));
        repeat (N + 10) nextCycle();
        applyStimulus("afterAbort", OP_XOR, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 32'h1234_A987, '0, 5'b00000, LAT1, 1'b1);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter M, default 4, meaning opcode (sel) width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a, b  input  N each  operands; b[$clog2(N)-1:0] is the shift amount for shift ops.
REQ-008 sel  input  M  opcode, values from alu_pkg.
REQ-009 cin  input  1  carry-in for RCA/RCS.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 res, res_hi  output  N each  result; res_hi = product high half (MUL), remainder (DIV), else 0.
REQ-013 cout, flag_neg, flag_overflow, flag_null, flag_err  output  1 each  status flags.

Function
REQ-014 Request SHALL be accepted on a cycle with in_valid && in_ready; a, b, sel, cin captured at that edge.
REQ-015 FSM states IDLE, EXEC, ITER, DONE; IDLE->EXEC (single-cycle op) or ITER (MUL/DIV) on accept; EXEC->DONE; ITER->DONE after N iterations; DONE->IDLE on out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; no new request accepted while busy.
REQ-017 RCA, RCS, AND, OR, XOR, SHIFT_LS, SHIFT_LD, SHIFT_AS, SHIFT_AD SHALL raise out_valid exactly 2 cycles after accept.
REQ-018 RCA: {cout,res}=a+b+cin; RCS: res=a-b-cin, cout = no-borrow; flag_overflow = signed overflow.
REQ-019 SHIFT_AS SHALL equal SHIFT_LS with flag_overflow=1 if any bit shifted out or the sign bit changes; SHIFT_AD SHALL replicate a[N-1].
REQ-020 MUL SHALL be unsigned shift-add, {res_hi,res}=a*b, out_valid N+2 cycles after accept; flag_overflow = (res_hi != 0).
REQ-021 DIV SHALL be unsigned restoring, res=a/b, res_hi=a%b, out_valid N+2 cycles after accept.
REQ-022 DIV with b==0 SHALL complete in 2 cycles with res=all ones, res_hi=a, flag_err=1.
REQ-023 Undefined opcode SHALL complete in 2 cycles with res=0, res_hi=0, flag_err=1.
REQ-024 flag_neg=res[N-1]; flag_null=(res==0) (MUL: {res_hi,res}==0); cout=0 for non-add/sub ops.
REQ-025 res, res_hi and all flags SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-026 out_valid and out_ready both 1 SHALL complete the transfer; in_ready rises the following cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, res=res_hi=0, all flags 0.
REQ-028 Reset during ITER or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN: defined -> DIV implemented per REQ-021/022; undefined -> DIV treated as undefined opcode (REQ-023) and no divider logic instantiated.

Structure
REQ-030 alu_pkg SHALL hold the opcode constants (incl. MUL, DIV) and the FSM state enum.
REQ-031 Iterative MUL/DIV datapath SHALL be sub-module alu_seq_muldiv (start/done, N-cycle).

Verification
REQ-032 N=32: RCA a=1,b=1,cin=0 -> res=2, cout=0, flags 0, out_valid 2 cycles after accept.
REQ-033 RCA a=0x7FFFFFFF,b=1 -> res=0x80000000, flag_overflow=1, flag_neg=1; RCS a=2,b=2 -> res=0, flag_null=1, cout=1.
REQ-034 SHIFT_AD a=0x80000002,b=1 -> res=0xC0000001; SHIFT_LD same -> 0x40000001.
REQ-035 MUL a=0xFFFFFFFF,b=2 -> res_hi=1, res=0xFFFFFFFE, flag_overflow=1, out_valid at cycle 34; in_ready=0 throughout.
REQ-036 DIV a=100,b=7 -> res=14, res_hi=2; b=0 -> res=0xFFFFFFFF, flag_err=1 (macro defined); flag_err=1, res=0 (undefined).
REQ-037 Hold out_ready=0 for 5 cycles -> outputs stable; rst_n pulse mid-MUL -> out_valid never asserted, in_ready=1 after release.
